// File: rtl/adc128s022_responder.sv
// -----------------------------------------------------------------------------
// adc128s022_responder
//
// Synthesisable stand-in for an ADC128S022 on the far side of the adc_sck /
// adc_cs_n / din / dout pins. Parallel 12-bit channel words are injected on
// ch_data. The responder decodes the 3-bit channel address shifted in on din
// and returns the addressed channel on dout, MSB first, in the device's
// 16-clock frame format (4 leading zeros, then 12 data bits).
//
// Ports
//   clk_50     : system clock; all logic on its rising edge
//   rst        : synchronous, active-high reset
//   adc_sck    : serial clock from the master (asynchronous, synchronised here)
//   adc_cs_n   : active-low chip select from the master
//   din        : control word from the master (address on rising edges 3..5)
//   ch_data    : NUM_CH packed samples, channel k at [k*CH_W +: CH_W]
//   dout       : serial sample to the master, 0 whenever dout_oe is 0
//   dout_oe    : high while a frame is active (models device tri-state)
//   frame_done : one-cycle pulse per completed 16-clock frame
//   conv_addr  : channel converted in the last completed frame
//   conv_data  : sample sent in the last completed frame
//
// Configuration
//   ADC_EMU_NOISE_EN : when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11)
//                      XORs its two LSBs into each latched sample and steps
//                      once on the cycle after every latch. When undefined
//                      no LFSR is built and samples pass through unchanged.
//
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module adc128s022_responder #(
  parameter int          CH_W        = 12,
  parameter int          NUM_CH      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] NOISE_SEED  = 16'hACE1
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     adc_sck,
  input  logic                     adc_cs_n,
  input  logic                     din,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic                     dout,
  output logic                     dout_oe,
  output logic                     frame_done,
  output logic [2:0]               conv_addr,
  output logic [CH_W-1:0]          conv_data
);

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    IDLE    = 2'd1,
    FRAME   = 2'd2
  } state_t;

  // Channels outside 0..NUM_CH-1 read as zero.
  function automatic logic [CH_W-1:0] select_channel(
    input logic [NUM_CH*CH_W-1:0] data,
    input logic [2:0]             addr
  );
    logic [CH_W-1:0] res;
    res = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      res = (addr == k[2:0]) ? data[k*CH_W +: CH_W] : res;
    end
    return res;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] din_sync_r;
  logic                   sck_prev_r;
  logic                   cs_prev_r;

  logic sck_s, cs_s, din_s;
  logic sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

  state_t          state_r;
  logic [4:0]      rise_cnt_r;
  logic [4:0]      fall_cnt_r;
  logic [2:0]      addr_cur_r;
  logic [2:0]      addr_next_r;
  logic [CH_W-1:0] sample_r;
  logic            dout_r;
  logic            dout_oe_r;
  logic            frame_done_r;
  logic [2:0]      conv_addr_r;
  logic [CH_W-1:0] conv_data_r;

  logic [4:0]      rise_nxt_s;
  logic [4:0]      fall_nxt_s;
  logic [2:0]      addr_nxt_s;
  logic [CH_W-1:0] sample_nxt_s;
  logic [CH_W-1:0] shifted_s;
  logic            dout_nxt_s;
  logic            latch_s;
  logic            done_s;
  logic            frame_act_s;
  logic [CH_W-1:0] noise_s;

  // Synchroniser chains plus one history flop for edge detection.
  // Chains clear to 0 so a chip select held low through reset is never
  // mistaken for a fresh falling edge.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      sck_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r  <= {SYNC_STAGES{1'b0}};
      din_sync_r <= {SYNC_STAGES{1'b0}};
      sck_prev_r <= 1'b0;
      cs_prev_r  <= 1'b0;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], adc_sck};
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], adc_cs_n};
      din_sync_r <= {din_sync_r[SYNC_STAGES-2:0], din};
      sck_prev_r <= sck_sync_r[SYNC_STAGES-1];
      cs_prev_r  <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign din_s      = din_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_r;
  assign sck_fall_s = ~sck_s & sck_prev_r;
  assign cs_rise_s  = cs_s & ~cs_prev_r;
  assign cs_fall_s  = ~cs_s & cs_prev_r;

  // SCK edges only count inside a frame that is not being aborted this cycle.
  assign frame_act_s = (state_r == FRAME) && !cs_rise_s;

  // Next-state datapath for one SCK edge inside a frame.
  always_comb begin
    rise_nxt_s   = rise_cnt_r;
    fall_nxt_s   = fall_cnt_r;
    addr_nxt_s   = addr_next_r;
    sample_nxt_s = sample_r;
    dout_nxt_s   = dout_r;
    latch_s      = 1'b0;
    // Falls 5..15 walk the sample MSB-1 down to bit 0.
    shifted_s    = sample_r << (fall_cnt_r - 5'd3);
    if (frame_act_s && sck_rise_s && (rise_cnt_r < 5'd16)) begin
      case (rise_cnt_r)
        5'd2:    addr_nxt_s[2] = din_s;
        5'd3:    addr_nxt_s[1] = din_s;
        5'd4:    addr_nxt_s[0] = din_s;
        default: addr_nxt_s    = addr_next_r;
      endcase
      rise_nxt_s = rise_cnt_r + 5'd1;
    end else if (frame_act_s && sck_fall_s && (fall_cnt_r < 5'd16)) begin
      fall_nxt_s = fall_cnt_r + 5'd1;
      if (fall_cnt_r == 5'd3) begin
        // Fourth fall: the sample is captured here and nowhere else.
        latch_s      = 1'b1;
        sample_nxt_s = select_channel(ch_data, addr_cur_r) ^ noise_s;
        dout_nxt_s   = sample_nxt_s[CH_W-1];
      end else if ((fall_cnt_r >= 5'd4) && (fall_cnt_r <= 5'd14)) begin
        dout_nxt_s = shifted_s[CH_W-1];
      end else begin
        dout_nxt_s = 1'b0;
      end
    end else begin
      dout_nxt_s = dout_r;
    end
    // Completion is judged on updated counts, so whichever edge is last wins.
    done_s = (rise_nxt_s == 5'd16) && (fall_nxt_s == 5'd16);
  end

`ifdef ADC_EMU_NOISE_EN
  logic [15:0] lfsr_r;
  logic        lfsr_step_r;

  function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Noise LFSR advances on the cycle after each sample latch.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      lfsr_r      <= NOISE_SEED;
      lfsr_step_r <= 1'b0;
    end else begin
      lfsr_step_r <= latch_s;
      if (lfsr_step_r) begin
        lfsr_r <= lfsr_advance(lfsr_r);
      end else begin
        lfsr_r <= lfsr_r;
      end
    end
  end

  assign noise_s = {{(CH_W-2){1'b0}}, lfsr_r[1:0]};
`else
  assign noise_s = {CH_W{1'b0}};
  logic unused_cfg_s;
  assign unused_cfg_s = latch_s ^ (^NOISE_SEED);
`endif

  // Frame control FSM with registered outputs.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_r      <= WAIT_HI;
      rise_cnt_r   <= 5'd0;
      fall_cnt_r   <= 5'd0;
      addr_cur_r   <= 3'd0;
      addr_next_r  <= 3'd0;
      sample_r     <= {CH_W{1'b0}};
      dout_r       <= 1'b0;
      dout_oe_r    <= 1'b0;
      frame_done_r <= 1'b0;
      conv_addr_r  <= 3'd0;
      conv_data_r  <= {CH_W{1'b0}};
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        WAIT_HI: begin
          // Re-arm only once CS has been seen high, so a reset inside a
          // frame cannot pick the frame up halfway.
          dout_r    <= 1'b0;
          dout_oe_r <= 1'b0;
          state_r   <= cs_s ? IDLE : WAIT_HI;
        end
        IDLE: begin
          dout_r <= 1'b0;
          if (cs_fall_s) begin
            state_r     <= FRAME;
            rise_cnt_r  <= 5'd0;
            fall_cnt_r  <= 5'd0;
            addr_cur_r  <= 3'd0;
            addr_next_r <= 3'd0;
            dout_oe_r   <= 1'b1;
          end else begin
            state_r   <= IDLE;
            dout_oe_r <= 1'b0;
          end
        end
        FRAME: begin
          if (cs_rise_s) begin
            state_r   <= IDLE;
            dout_r    <= 1'b0;
            dout_oe_r <= 1'b0;
          end else begin
            state_r     <= FRAME;
            dout_oe_r   <= 1'b1;
            dout_r      <= dout_nxt_s;
            sample_r    <= sample_nxt_s;
            addr_next_r <= addr_nxt_s;
            if (done_s) begin
              // Frame complete: publish it and chain straight into the next.
              frame_done_r <= 1'b1;
              conv_addr_r  <= addr_cur_r;
              conv_data_r  <= sample_nxt_s;
              addr_cur_r   <= addr_nxt_s;
              rise_cnt_r   <= 5'd0;
              fall_cnt_r   <= 5'd0;
            end else begin
              rise_cnt_r <= rise_nxt_s;
              fall_cnt_r <= fall_nxt_s;
            end
          end
        end
        default: begin
          state_r   <= WAIT_HI;
          dout_r    <= 1'b0;
          dout_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_r;
  assign dout_oe    = dout_oe_r;
  assign frame_done = frame_done_r;
  assign conv_addr  = conv_addr_r;
  assign conv_data  = conv_data_r;

endmodule

// File: tb/tb_adc128s022_responder.sv
// -----------------------------------------------------------------------------
// tb_adc128s022_responder
//
// Drives SPI frames into adc128s022_responder in both SCK idle polarities,
// with directed scenarios (reset, plain frame, back-to-back frame, CS abort,
// reset mid-frame) followed by randomised sessions. Expected serial words and
// conv_* values come from a frame-level model: each CS fall starts at ch0,
// each completed frame selects the channel addressed in din bits 3..5, and
// the sample is the channel value present at the fourth SCK fall.
// -----------------------------------------------------------------------------
module tb_adc128s022_responder;

  localparam int          CH_W   = 12;
  localparam int          NUM_CH = 8;
  localparam int          HALF   = 12;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic                   clk_50   = 1'b0;
  logic                   rst      = 1'b1;
  logic                   adc_sck  = 1'b1;
  logic                   adc_cs_n = 1'b1;
  logic                   din      = 1'b0;
  logic [NUM_CH*CH_W-1:0] ch_data  = '0;
  logic                   dout;
  logic                   dout_oe;
  logic                   frame_done;
  logic [2:0]             conv_addr;
  logic [CH_W-1:0]        conv_data;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  logic scramble_en = 1'b0;

  logic [15:0]     m_lfsr;
  logic [2:0]      m_addr_cur;
  logic [2:0]      m_conv_addr;
  logic [CH_W-1:0] m_conv_data;

  adc128s022_responder #(
    .CH_W       (CH_W),
    .NUM_CH     (NUM_CH),
    .SYNC_STAGES(2),
    .NOISE_SEED (SEED)
  ) dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .adc_sck   (adc_sck),
    .adc_cs_n  (adc_cs_n),
    .din       (din),
    .ch_data   (ch_data),
    .dout      (dout),
    .dout_oe   (dout_oe),
    .frame_done(frame_done),
    .conv_addr (conv_addr),
    .conv_data (conv_data)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) begin
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  function automatic logic [CH_W-1:0] chan(input logic [2:0] a);
    return ch_data[int'(a)*CH_W +: CH_W];
  endfunction

  function automatic logic din_bit(input int k, input logic [2:0] a);
    if (k == 3) return a[2];
    else if (k == 4) return a[1];
    else if (k == 5) return a[0];
    else return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic randomize_channels();
    for (int i = 0; i < NUM_CH; i++) ch_data[i*CH_W +: CH_W] = CH_W'($urandom);
  endtask

  // One 16-clock frame. abort_at>0 stops after that many falls, by raising
  // CS (abort_rst=0) or by pulsing reset with CS held low (abort_rst=1).
  task automatic do_frame(input logic cpol, input logic start_cs, input logic [2:0] addr,
                          input int abort_at, input logic abort_rst);
    logic [15:0]     word;
    logic [CH_W-1:0] exp_smp;
    logic [1:0]      noise;
    logic            stopped;
    int              done0;
    word    = '0;
    exp_smp = '0;
    noise   = 2'b00;
    stopped = 1'b0;
    done0   = done_cnt;
    din     = din_bit(1, addr);
    if (start_cs) begin
      adc_sck = cpol;
      wait_clks(HALF);
      adc_cs_n   = 1'b0;
      m_addr_cur = 3'd0;
      wait_clks(HALF);
      check_eq("oe_on", 32'(dout_oe), 32'd1);
    end
    word[15] = dout;
    for (int k = 1; k <= 16 && !stopped; k++) begin
      if (!cpol) begin
        adc_sck = 1'b1;
        wait_clks(HALF);
      end
      adc_sck = 1'b0;
      din     = cpol ? din_bit(k, addr) : din_bit(k + 1, addr);
      if (k == 4) begin
`ifdef ADC_EMU_NOISE_EN
        noise  = m_lfsr[1:0];
        m_lfsr = lfsr_next(m_lfsr);
`endif
        exp_smp = chan(m_addr_cur) ^ {{(CH_W-2){1'b0}}, noise};
      end
      wait_clks(HALF);
      if (k < 16) word[15-k] = dout;
      if (k == 6 && scramble_en) randomize_channels();
      if (k == abort_at) begin
        stopped = 1'b1;
      end else if (cpol) begin
        adc_sck = 1'b1;
        wait_clks(HALF);
      end
    end
    if (stopped && abort_rst) begin
      rst = 1'b1;
      wait_clks(3);
      rst         = 1'b0;
      m_lfsr      = SEED;
      m_conv_addr = 3'd0;
      m_conv_data = '0;
      wait_clks(2);
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_oe", 32'(dout_oe), 32'd0);
      check_eq("rst_conv_addr", 32'(conv_addr), 32'd0);
      check_eq("rst_conv_data", 32'(conv_data), 32'd0);
      repeat (4) begin
        adc_sck = 1'b1;
        wait_clks(HALF);
        adc_sck = 1'b0;
        wait_clks(HALF);
      end
      check_eq("rst_sck_ignored_oe", 32'(dout_oe), 32'd0);
      check_eq("rst_sck_ignored_done", 32'(done_cnt), 32'(done0));
      adc_cs_n = 1'b1;
      wait_clks(HALF);
    end else if (stopped) begin
      adc_cs_n = 1'b1;
      wait_clks(HALF);
      check_eq("abort_oe", 32'(dout_oe), 32'd0);
      check_eq("abort_dout", 32'(dout), 32'd0);
      check_eq("abort_no_done", 32'(done_cnt), 32'(done0));
      check_eq("abort_conv_addr", 32'(conv_addr), 32'(m_conv_addr));
      check_eq("abort_conv_data", 32'(conv_data), 32'(m_conv_data));
    end else begin
      m_conv_addr = m_addr_cur;
      m_conv_data = exp_smp;
      m_addr_cur  = addr;
      check_eq("frame_word", 32'(word), 32'({4'b0000, exp_smp}));
      check_eq("frame_done_count", 32'(done_cnt), 32'(done0 + 1));
      check_eq("conv_addr", 32'(conv_addr), 32'(m_conv_addr));
      check_eq("conv_data", 32'(conv_data), 32'(m_conv_data));
    end
  endtask

  task automatic end_session();
    adc_cs_n = 1'b1;
    wait_clks(HALF);
    check_eq("cs_high_oe", 32'(dout_oe), 32'd0);
    check_eq("cs_high_dout", 32'(dout), 32'd0);
  endtask

  initial begin
    logic       cpol;
    int         nfr;
    int         ab;
    logic [2:0] a;

    // Reset with CS high.
    rst      = 1'b1;
    adc_cs_n = 1'b1;
    adc_sck  = 1'b1;
    wait_clks(3);
    check_eq("reset_dout", 32'(dout), 32'd0);
    check_eq("reset_oe", 32'(dout_oe), 32'd0);
    check_eq("reset_done", 32'(frame_done), 32'd0);
    check_eq("reset_conv_addr", 32'(conv_addr), 32'd0);
    check_eq("reset_conv_data", 32'(conv_data), 32'd0);
    rst         = 1'b0;
    m_lfsr      = SEED;
    m_addr_cur  = 3'd0;
    m_conv_addr = 3'd0;
    m_conv_data = '0;
    wait_clks(HALF);

    // Frame 1 sends ch0 and addresses ch5; frame 2 (CS still low) sends ch5.
    ch_data[0*CH_W +: CH_W] = 12'hABC;
    ch_data[5*CH_W +: CH_W] = 12'h123;
    do_frame(1'b1, 1'b1, 3'd5, 0, 1'b0);
    do_frame(1'b1, 1'b0, 3'd3, 0, 1'b0);
    // Frame addressing ch3 aborted after 8 falls; the next frame is ch0 again.
    do_frame(1'b1, 1'b0, 3'd3, 8, 1'b0);
    do_frame(1'b1, 1'b1, 3'd2, 0, 1'b0);
    end_session();

    // Idle-low SCK: reset at fall 6 with CS low, then a clean restart at ch0.
    ch_data[1*CH_W +: CH_W] = 12'h5A5;
    do_frame(1'b0, 1'b1, 3'd4, 6, 1'b1);
    do_frame(1'b0, 1'b1, 3'd1, 0, 1'b0);
    do_frame(1'b0, 1'b0, 3'd6, 0, 1'b0);
    end_session();

    // Randomised sessions with back-to-back frames and occasional aborts.
    scramble_en = 1'b1;
    for (int s = 0; s < 24; s++) begin
      cpol = 1'($urandom_range(1, 0));
      nfr  = int'($urandom_range(3, 1));
      randomize_channels();
      ab = 0;
      for (int f = 0; f < nfr; f++) begin
        a  = 3'($urandom_range(7, 0));
        ab = ((f == nfr - 1) && ($urandom_range(3, 0) == 0)) ? int'($urandom_range(15, 1)) : 0;
        do_frame(cpol, (f == 0) ? 1'b1 : 1'b0, a, ab, 1'b0);
      end
      if (ab == 0) end_session();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
